// File: rtl/axis_master_tx_if.sv
// Backend push port and AXI4-Stream master signals for axis_master_tx.
// master: transmitter side; slave: backend driver plus stream sink.
interface axis_master_tx_if;
  logic        bk_valid;
  logic [31:0] bk_data;
  logic [3:0]  bk_tstrb;
  logic [3:0]  bk_tkeep;
  logic [1:0]  bk_user;
  logic        bk_last;
  logic        bk_ready;
  logic        bk_done;
  logic        axis_tvalid;
  logic [31:0] axis_tdata;
  logic [3:0]  axis_tstrb;
  logic [3:0]  axis_tkeep;
  logic        axis_tlast;
  logic [1:0]  axis_tuser;
  logic        axis_tready;

  modport master (
    input  bk_valid, bk_data, bk_tstrb,
    input  bk_tkeep, bk_user, bk_last,
    input  axis_tready,
    output bk_ready, bk_done,
    output axis_tvalid, axis_tdata,
    output axis_tstrb, axis_tkeep,
    output axis_tlast, axis_tuser
  );

  modport slave (
    output bk_valid, bk_data, bk_tstrb,
    output bk_tkeep, bk_user, bk_last,
    output axis_tready,
    input  bk_ready, bk_done,
    input  axis_tvalid, axis_tdata,
    input  axis_tstrb, axis_tkeep,
    input  axis_tlast, axis_tuser
  );
endinterface

// File: rtl/axis_master_tx.sv
// AXI4-Stream transmitter: backend beats buffered in a DEPTH FIFO.
// Ports: axi_aclk, axi_aresetn, bus (master), fifo_level, tx_beats.
module axis_master_tx #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  axis_master_tx_if.master       bus,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       tx_beats
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic [1:0]  user;
    logic        last;
  } beat_t;

  beat_t            mem_q [DEPTH];
  beat_t            head;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty, full;
  logic             push, pop;

  // Extra wrap bit tells full from empty when indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
              && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign push = bus.bk_valid && !full;
  assign pop  = !empty && bus.axis_tready;
  assign head = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      cnt_d    = cnt_q + CNT_W'(1);
      done_d   = head.last;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge axi_aclk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {bus.bk_data, bus.bk_tstrb,
                                  bus.bk_tkeep, bus.bk_user,
                                  bus.bk_last};
    end
  end

  assign bus.bk_ready    = !full;
  assign bus.bk_done     = done_q;
  assign bus.axis_tvalid = !empty;
  assign bus.axis_tdata  = head.data;
  assign bus.axis_tstrb  = head.strb;
  assign bus.axis_tkeep  = head.keep;
  assign bus.axis_tuser  = head.user;
  assign bus.axis_tlast  = head.last;

  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign tx_beats   = cnt_q;
endmodule

// File: tb/tb_axis_master_tx.sv
// Self-checking bench for axis_master_tx.
// Queue-based reference model, randomized stimulus.
module tb_axis_master_tx;
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic [3:0]  k;
    logic [1:0]  u;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  fifo_level;
  logic [15:0] tx_beats;
  logic [2:0]  lvl4;
  logic [3:0]  tx4;

  int    total = 0;
  int    bad = 0;
  int    exp_beats = 0;
  int    done_cnt = 0;
  beat_t got_q[$];

  axis_master_tx_if b();
  axis_master_tx_if b4();

  axis_master_tx #(.DEPTH(4), .CNT_W(16)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n), .bus(b),
    .fifo_level(fifo_level), .tx_beats(tx_beats)
  );

  axis_master_tx #(.DEPTH(4), .CNT_W(4)) dut4 (
    .axi_aclk(clk), .axi_aresetn(rst_n), .bus(b4),
    .fifo_level(lvl4), .tx_beats(tx4)
  );

  always #5 clk = ~clk;

  // Mid-cycle observer: records every completed AXIS beat and done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b.axis_tvalid && b.axis_tready)
        got_q.push_back({b.axis_tdata, b.axis_tstrb, b.axis_tkeep,
                         b.axis_tuser, b.axis_tlast});
      if (b.bk_done) done_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t rnd_beat(logic l);
    beat_t x;
    x.d = $urandom;
    x.s = 4'($urandom);
    x.k = 4'($urandom);
    x.u = 2'($urandom);
    x.l = l;
    return x;
  endfunction

  task automatic drive(beat_t x, logic v);
    b.bk_valid = v;
    b.bk_data  = x.d;
    b.bk_tstrb = x.s;
    b.bk_tkeep = x.k;
    b.bk_user  = x.u;
    b.bk_last  = x.l;
  endtask

  function automatic beat_t head_out();
    beat_t o;
    o = {b.axis_tdata, b.axis_tstrb, b.axis_tkeep,
         b.axis_tuser, b.axis_tlast};
    return o;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (b.axis_tvalid !== 1'b0) begin
      bad++; $display("FAIL rst_tvalid got=%0b want=0", b.axis_tvalid);
    end
    total++;
    if (b.bk_ready !== 1'b1) begin
      bad++; $display("FAIL rst_bk_ready got=%0b want=1", b.bk_ready);
    end
    total++;
    if (b.bk_done !== 1'b0) begin
      bad++; $display("FAIL rst_bk_done got=%0b want=0", b.bk_done);
    end
    total++;
    if (tx_beats !== 16'd0) begin
      bad++; $display("FAIL rst_tx_beats got=%0d want=0", tx_beats);
    end
    total++;
    if (fifo_level !== 3'd0) begin
      bad++; $display("FAIL rst_level got=%0d want=0", fifo_level);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single;
    beat_t x;
    beat_t o;
    x = '{d: 32'hA5A5_0001, s: 4'hF, k: 4'hF, u: 2'b01, l: 1'b1};
    got_q.delete();
    done_cnt = 0;
    b.axis_tready = 1'b1;
    drive(x, 1'b1);
    total++;
    if (b.axis_tvalid !== 1'b0) begin
      bad++; $display("FAIL single_pre_tvalid got=%0b want=0", b.axis_tvalid);
    end
    tick;
    drive(x, 1'b0);
    o = head_out();
    total++;
    if (b.axis_tvalid !== 1'b1) begin
      bad++; $display("FAIL single_tvalid got=%0b want=1", b.axis_tvalid);
    end
    total++;
    if (o !== x) begin
      bad++; $display("FAIL single_payload got=%h want=%h", o, x);
    end
    tick;
    total++;
    if (b.bk_done !== 1'b1) begin
      bad++; $display("FAIL single_done got=%0b want=1", b.bk_done);
    end
    total++;
    if (tx_beats !== 16'd1) begin
      bad++; $display("FAIL single_tx_beats got=%0d want=1", tx_beats);
    end
    tick;
    total++;
    if (b.bk_done !== 1'b0) begin
      bad++; $display("FAIL single_done_clr got=%0b want=0", b.bk_done);
    end
    exp_beats = 1;
  endtask

  task automatic test_backpressure;
    beat_t bp[5];
    int    lasts;
    int    n;
    lasts = 0;
    got_q.delete();
    done_cnt = 0;
    b.axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bp[i] = rnd_beat(1'($urandom_range(0, 1)));
      lasts += int'(bp[i].l);
    end
    for (int i = 0; i < 4; i++) begin
      drive(bp[i], 1'b1);
      tick;
    end
    drive(bp[4], 1'b1);
    total++;
    if (b.bk_ready !== 1'b0) begin
      bad++; $display("FAIL bp_full_ready got=%0b want=0", b.bk_ready);
    end
    total++;
    if (fifo_level !== 3'd4) begin
      bad++; $display("FAIL bp_level got=%0d want=4", fifo_level);
    end
    for (int c = 0; c < 3; c++) begin
      tick;
      total++;
      if (b.bk_ready !== 1'b0 || b.axis_tvalid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold_flags ready=%0b valid=%0b want=0/1",
                 b.bk_ready, b.axis_tvalid);
      end
      total++;
      if (head_out() !== bp[0]) begin
        bad++; $display("FAIL bp_stable got=%h want=%h", head_out(), bp[0]);
      end
    end
    b.axis_tready = 1'b1;
    tick;
    total++;
    if (b.bk_ready !== 1'b1) begin
      bad++; $display("FAIL bp_reready got=%0b want=1", b.bk_ready);
    end
    total++;
    if (fifo_level !== 3'd3) begin
      bad++; $display("FAIL bp_level_pop got=%0d want=3", fifo_level);
    end
    tick;
    drive(bp[4], 1'b0);
    n = 0;
    while (fifo_level != 3'd0 && n < 20) begin
      tick;
      n++;
    end
    tick;
    total++;
    if (n >= 20) begin
      bad++; $display("FAIL bp_drain_timeout got=%0d want<20", n);
    end
    total++;
    if (got_q.size() != 5) begin
      bad++; $display("FAIL bp_count got=%0d want=5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (got_q[i] !== bp[i]) begin
          bad++; $display("FAIL bp_order[%0d] got=%h want=%h", i, got_q[i], bp[i]);
        end
      end
    end
    total++;
    if (done_cnt != lasts) begin
      bad++; $display("FAIL bp_dones got=%0d want=%0d", done_cnt, lasts);
    end
    exp_beats += 5;
    total++;
    if (tx_beats !== 16'(exp_beats)) begin
      bad++; $display("FAIL bp_tx_beats got=%0d want=%0d", tx_beats, exp_beats);
    end
  endtask

  task automatic test_stream;
    beat_t st[64];
    beat_t prev;
    logic  hold;
    logic  v;
    logic  acc;
    int    idx;
    int    cyc;
    int    lasts;
    int    lvl;
    idx = 0;
    cyc = 0;
    lasts = 0;
    hold = 1'b0;
    prev = '0;
    got_q.delete();
    done_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      st[i] = rnd_beat(1'($urandom_range(0, 4) == 0));
      lasts += int'(st[i].l);
    end
    while ((idx < 64 || fifo_level != 3'd0) && cyc < 2000) begin
      lvl = idx - got_q.size();
      total++;
      if (fifo_level !== 3'(lvl) || b.axis_tvalid !== (lvl != 0)
          || b.bk_ready !== (lvl < 4)) begin
        bad++;
        $display("FAIL st_level cyc=%0d got=%0d/%0b/%0b want=%0d",
                 cyc, fifo_level, b.axis_tvalid, b.bk_ready, lvl);
      end
      if (hold) begin
        total++;
        if (b.axis_tvalid !== 1'b1 || head_out() !== prev) begin
          bad++; $display("FAIL st_stable got=%h want=%h", head_out(), prev);
        end
      end
      v = (idx < 64) && ($urandom_range(0, 1) == 1);
      drive(st[(idx < 64) ? idx : 63], v);
      b.axis_tready = ($urandom_range(0, 3) != 0);
      acc = v && b.bk_ready;
      hold = b.axis_tvalid && !b.axis_tready;
      prev = head_out();
      tick;
      cyc++;
      if (acc) idx++;
    end
    drive(st[63], 1'b0);
    b.axis_tready = 1'b1;
    tick;
    total++;
    if (cyc >= 2000) begin
      bad++; $display("FAIL st_timeout got=%0d want<2000", cyc);
    end
    total++;
    if (got_q.size() != 64) begin
      bad++; $display("FAIL st_count got=%0d want=64", got_q.size());
    end else begin
      for (int i = 0; i < 64; i++) begin
        total++;
        if (got_q[i] !== st[i]) begin
          bad++; $display("FAIL st_order[%0d] got=%h want=%h", i, got_q[i], st[i]);
        end
      end
    end
    total++;
    if (done_cnt != lasts) begin
      bad++; $display("FAIL st_dones got=%0d want=%0d", done_cnt, lasts);
    end
    exp_beats += 64;
    total++;
    if (tx_beats !== 16'(exp_beats)) begin
      bad++; $display("FAIL st_tx_beats got=%0d want=%0d", tx_beats, exp_beats);
    end
  endtask

  task automatic test_back_to_back;
    beat_t sm[12];
    int    n;
    got_q.delete();
    done_cnt = 0;
    for (int i = 0; i < 12; i++) sm[i] = rnd_beat(1'b0);
    b.axis_tready = 1'b0;
    drive(sm[0], 1'b1);
    tick;
    drive(sm[1], 1'b1);
    tick;
    b.axis_tready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive(sm[c+2], 1'b1);
      total++;
      if (fifo_level !== 3'd2) begin
        bad++; $display("FAIL b2b_level[%0d] got=%0d want=2", c, fifo_level);
      end
      total++;
      if (head_out() !== sm[c]) begin
        bad++; $display("FAIL b2b_head[%0d] got=%h want=%h", c, head_out(), sm[c]);
      end
      tick;
    end
    drive(sm[11], 1'b0);
    total++;
    if (got_q.size() != 10) begin
      bad++; $display("FAIL b2b_rate got=%0d want=10", got_q.size());
    end
    n = 0;
    while (fifo_level != 3'd0 && n < 20) begin
      tick;
      n++;
    end
    tick;
    total++;
    if (got_q.size() != 12) begin
      bad++; $display("FAIL b2b_count got=%0d want=12", got_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        total++;
        if (got_q[i] !== sm[i]) begin
          bad++; $display("FAIL b2b_order[%0d] got=%h want=%h", i, got_q[i], sm[i]);
        end
      end
    end
    exp_beats += 12;
    total++;
    if (tx_beats !== 16'(exp_beats)) begin
      bad++; $display("FAIL b2b_tx_beats got=%0d want=%0d", tx_beats, exp_beats);
    end
  endtask

  task automatic test_reset_mid;
    beat_t pk[3];
    beat_t np[2];
    for (int i = 0; i < 3; i++) pk[i] = rnd_beat(1'b0);
    np[0] = rnd_beat(1'b0);
    np[1] = rnd_beat(1'b1);
    b.axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(pk[i], 1'b1);
      tick;
    end
    drive(pk[2], 1'b0);
    total++;
    if (fifo_level !== 3'd3) begin
      bad++; $display("FAIL rm_pre_level got=%0d want=3", fifo_level);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (b.axis_tvalid !== 1'b0 || b.bk_ready !== 1'b1) begin
      bad++;
      $display("FAIL rm_async valid=%0b ready=%0b want=0/1",
               b.axis_tvalid, b.bk_ready);
    end
    total++;
    if (tx_beats !== 16'd0 || fifo_level !== 3'd0) begin
      bad++;
      $display("FAIL rm_counts tx=%0d lvl=%0d want=0/0", tx_beats, fifo_level);
    end
    exp_beats = 0;
    tick;
    rst_n = 1'b1;
    tick;
    got_q.delete();
    done_cnt = 0;
    b.axis_tready = 1'b1;
    drive(np[0], 1'b1);
    tick;
    drive(np[1], 1'b1);
    tick;
    drive(np[1], 1'b0);
    repeat (3) tick;
    total++;
    if (got_q.size() != 2) begin
      bad++; $display("FAIL rm_count got=%0d want=2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got_q[i] !== np[i]) begin
          bad++; $display("FAIL rm_order[%0d] got=%h want=%h", i, got_q[i], np[i]);
        end
      end
    end
    total++;
    if (done_cnt != 1) begin
      bad++; $display("FAIL rm_dones got=%0d want=1", done_cnt);
    end
    exp_beats = 2;
    total++;
    if (tx_beats !== 16'(exp_beats)) begin
      bad++; $display("FAIL rm_tx_beats got=%0d want=%0d", tx_beats, exp_beats);
    end
  endtask

  task automatic test_wrap;
    int pops;
    b4.axis_tready = 1'b1;
    b4.bk_valid = 1'b1;
    b4.bk_data = 32'd0;
    for (int k = 1; k < 20; k++) begin
      tick;
      if (k >= 17) b4.bk_valid = 1'b0;
      else b4.bk_data = 32'(k);
      pops = (k - 1 > 17) ? 17 : k - 1;
      total++;
      if (tx4 !== 4'(pops % 16)) begin
        bad++; $display("FAIL wrap_cnt k=%0d got=%0d want=%0d", k, tx4, pops % 16);
      end
    end
  endtask

  initial begin
    b.bk_valid = 1'b0;
    b.bk_data = '0;
    b.bk_tstrb = '0;
    b.bk_tkeep = '0;
    b.bk_user = '0;
    b.bk_last = 1'b0;
    b.axis_tready = 1'b0;
    b4.bk_valid = 1'b0;
    b4.bk_data = '0;
    b4.bk_tstrb = 4'hF;
    b4.bk_tkeep = 4'hF;
    b4.bk_user = '0;
    b4.bk_last = 1'b0;
    b4.axis_tready = 1'b0;
    test_reset;
    test_single;
    test_backpressure;
    test_stream;
    test_back_to_back;
    test_reset_mid;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/axis_master_tx.md
# axis_master_tx

AXI4-Stream transmitter for the fsic axilite_axis path. It is the outbound counterpart of the stream slave. A backend block pushes beats through a valid/ready port. The beats are buffered in a small FIFO and driven onto the AXIS master signals with full tvalid/tready compliance. It also reports one `bk_done` pulse per packet sent and keeps a running count of transmitted beats.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the transmitted-beat counter.

Ports:
- axi_aclk  in  1  single clock; all logic is rising-edge.
- axi_aresetn  in  1  reset, asynchronous assert, active-low.
- bk_valid  in  1  backend offers a beat.
- bk_data  in  32  beat data.
- bk_tstrb  in  4  byte strobes.
- bk_tkeep  in  4  byte keeps.
- bk_user  in  2  sideband user bits.
- bk_last  in  1  beat ends the packet.
- bk_ready  out  1  FIFO can accept a beat.
- bk_done  out  1  one-cycle pulse when a tlast beat completes on AXIS.
- axis_tvalid  out  1  stream valid.
- axis_tdata  out  32  stream data.
- axis_tstrb  out  4  stream strobes.
- axis_tkeep  out  4  stream keeps.
- axis_tlast  out  1  packet end.
- axis_tuser  out  2  user bits.
- axis_tready  in  1  downstream ready.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- tx_beats  out  CNT_W  count of completed AXIS beats; wraps.

## Operation
- Push: bk_valid && bk_ready. Writes {data, tstrb, tkeep, user, last} at wr_ptr, then wr_ptr increments.
- Pop: axis_tvalid && axis_tready. rd_ptr increments.
- Pointers are $clog2(DEPTH)+1 bits with a wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
- bk_ready = !full. It is combinational from registered pointers only and never depends on bk_valid.
- axis_tvalid = !empty. All axis_t* payload outputs come from the entry at rd_ptr.
- Payload outputs are don't-care while tvalid=0. They are driven from stored registers, never from backend inputs.
- Push and pop in the same cycle: both occur and fifo_level is unchanged. When full, no push occurs that cycle; this is allowed because bk_ready depends only on full.
- bk_done is registered. It is 1 in the cycle after a pop whose tlast=1, and 0 otherwise.
- tx_beats increments by 1 on every pop and wraps from 2^CNT_W-1 to 0.
- Backend data is passed through unmodified. No tstrb/tkeep checking is done.

## Timing
- Reset (axi_aresetn=0) acts immediately and asynchronously:
  - pointers = 0, so axis_tvalid = 0 and bk_ready = 1;
  - bk_done = 0, tx_beats = 0, fifo_level = 0;
  - FIFO storage contents are not reset and are don't-care.
- Reset mid-packet discards all buffered beats. No tlast is emitted for the truncated packet.
- Latency: a beat pushed at edge N with the FIFO empty gives axis_tvalid=1 after edge N, i.e. one cycle. There is no combinational bk→axis path.
- Throughput: 1 beat/cycle sustained when axis_tready is held high.
- AXIS rules:
  - Once axis_tvalid=1, it and all payload outputs stay stable until a cycle with axis_tready=1.
  - tvalid never depends on tready.
- axis_tready high while the FIFO is empty has no effect.
- bk_ready deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the first pop.

## Test plan
1. Single beat: push data=0xA5A5_0001, tstrb=0xF, tkeep=0xF, user=2'b01, last=1 with tready=1. Expect tvalid=1 exactly one cycle later with identical payload and tlast=1. Expect bk_done pulse one cycle after the handshake and tx_beats=1.
2. Backpressure/full: tready=0, push 5 beats (DEPTH=4). Expect bk_ready=0 after the 4th push, the 5th beat held off, fifo_level=4, and axis_tdata stable at beat 0. Raise tready. Expect beats 0..4 in order and bk_ready=1 the cycle after the first pop.
3. Streaming: 64 consecutive beats with random bk_valid and random tready (≥50%). Scoreboard exact order and payload with no loss or duplication. Expect tx_beats=64, and bk_done count equal to the number of bk_last beats.
4. Simultaneous push/pop at level 2 with tready=1 and bk_valid=1 for 10 cycles. Expect fifo_level constantly 2 and one beat out per cycle.
5. Reset mid-packet: push 3 beats of a 6-beat packet, assert axi_aresetn=0 asynchronously between edges. Expect tvalid=0 and bk_ready=1 immediately, and tx_beats=0. After release, a new 2-beat packet is transmitted cleanly.
6. Counter wrap: CNT_W=4, send 17 beats. Expect tx_beats sequence …15, 0, 1.
